// File: rtl/dpwm_pkg.sv
// Shared widths, FSM encoding and saturation helper for the buck loop.
// Soft-start clamp is enabled in pid_compensator by PID_SOFT_START_EN.
package dpwm_pkg;

  localparam int ADC_W_DEF  = 8;
  localparam int DUTY_W_DEF = 9;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MA   = 3'd1;
  localparam logic [2:0] S_MB   = 3'd2;
  localparam logic [2:0] S_MC   = 3'd3;
  localparam logic [2:0] S_SAT  = 3'd4;

  function automatic logic signed [63:0] sat_range(
    input logic signed [63:0] x,
    input logic signed [63:0] lo,
    input logic signed [63:0] hi
  );
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Registered signed multiply-accumulate shared by the three PID taps.
// The FSM state selects which coefficient/error pair is accumulated.
module pid_mac
  import dpwm_pkg::*;
#(
  parameter int ERR_W  = 9,
  parameter int COEF_W = 12,
  parameter int ACC_W  = 29,
  parameter int KA     = 384,
  parameter int KB     = -640,
  parameter int KC     = 272
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [2:0]              sel,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic signed [ERR_W-1:0] e0,
  input  logic signed [ERR_W-1:0] e1,
  input  logic signed [ERR_W-1:0] e2,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PROD_W = ERR_W + COEF_W;

  localparam logic signed [COEF_W-1:0] KA_C = COEF_W'(KA);
  localparam logic signed [COEF_W-1:0] KB_C = COEF_W'(KB);
  localparam logic signed [COEF_W-1:0] KC_C = COEF_W'(KC);

  logic signed [COEF_W-1:0] coef;
  logic signed [ERR_W-1:0]  op;
  logic                     mac_en;
  logic signed [PROD_W-1:0] prod;

  always_comb begin
    coef   = '0;
    op     = '0;
    mac_en = 1'b0;
    unique case (1'b1)
      sel == S_MA: begin
        coef   = KA_C;
        op     = e0;
        mac_en = 1'b1;
      end
      sel == S_MB: begin
        coef   = KB_C;
        op     = e1;
        mac_en = 1'b1;
      end
      sel == S_MC: begin
        coef   = KC_C;
        op     = e2;
        mac_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign prod = PROD_W'(coef) * PROD_W'(op);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (mac_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/pid_compensator.sv
// Incremental 3-tap PID feeding the dither DPWM duty input.
// Define PID_SOFT_START_EN to ramp the duty ceiling by SS_STEP per update.
module pid_compensator
  import dpwm_pkg::*;
#(
  parameter int ADC_W     = ADC_W_DEF,
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int COEF_W    = 12,
  parameter int COEF_FRAC = 8,
  parameter int KA        = 384,
  parameter int KB        = -640,
  parameter int KC        = 272,
  parameter int DUTY_MAX  = 511,
  parameter int SS_STEP   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  vref,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int ERR_W = ADC_W + 1;
  localparam int U_W   = DUTY_W + COEF_FRAC;
  localparam int ACC_W = DUTY_W + COEF_FRAC + ADC_W + 4;

  logic [2:0]              state;
  logic signed [ERR_W-1:0] e0;
  logic signed [ERR_W-1:0] e1;
  logic signed [ERR_W-1:0] e2;
  logic signed [ERR_W-1:0] e_new;
  logic [U_W-1:0]          u;
  logic [U_W-1:0]          u_sat;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] u_ext;
  logic [DUTY_W-1:0]       ub;
  logic signed [63:0]      hi;
  logic                    take;

  assign take  = (state == S_IDLE) && adc_valid;
  assign busy  = (state != S_IDLE);
  assign e_new = $signed({1'b0, vref}) - $signed({1'b0, adc_data});
  assign u_ext = ACC_W'($signed({1'b0, u}));

`ifdef PID_SOFT_START_EN
  logic [DUTY_W-1:0] lim;
  logic [DUTY_W-1:0] lim_nxt;
  logic [DUTY_W:0]   lim_inc;

  assign lim_inc = {1'b0, lim} + (DUTY_W+1)'(SS_STEP);
  assign lim_nxt = (lim_inc > (DUTY_W+1)'(DUTY_MAX))
                 ? DUTY_W'(DUTY_MAX) : lim_inc[DUTY_W-1:0];
  // Ceiling for this update is the value before the increment.
  assign ub = lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      lim <= '0;
    end else if (state == S_SAT) begin
      lim <= lim_nxt;
    end
  end
`else
  assign ub = DUTY_W'(DUTY_MAX);
`endif

  assign hi    = 64'(ub) << COEF_FRAC;
  assign u_sat = U_W'(sat_range(64'(acc), 64'sd0, hi));

  pid_mac #(
    .ERR_W  (ERR_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .KA     (KA),
    .KB     (KB),
    .KC     (KC)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .load     (take),
    .sel      (state),
    .load_val (u_ext),
    .e0       (e0),
    .e1       (e1),
    .e2       (e2),
    .acc      (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      e0         <= '0;
      e1         <= '0;
      e2         <= '0;
      u          <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      overrun    <= adc_valid && (state != S_IDLE);
      unique case (1'b1)
        state == S_IDLE: begin
          if (adc_valid) begin
            e0    <= e_new;
            state <= S_MA;
          end
        end
        state == S_MA: state <= S_MB;
        state == S_MB: state <= S_MC;
        state == S_MC: state <= S_SAT;
        state == S_SAT: begin
          // Clamped value is fed back so the integrator cannot wind up.
          u          <= u_sat;
          duty       <= u_sat[U_W-1:COEF_FRAC];
          duty_valid <= 1'b1;
          e2         <= e1;
          e1         <= e0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_compensator.sv
// Bench for pid_compensator: default-coefficient instance plus a
// KA-only instance for saturation and soft-start sequences.
module tb_pid_compensator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [8:0] duty;
    int         due;
  } exp_t;

  typedef struct {
    bit rst;
    int vref;
    int adc;
    int exp;
    int gap;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  vec_t va[$];

  logic       a_rst = 1'b1;
  logic [7:0] a_adc = '0;
  logic [7:0] a_vref = '0;
  logic       a_valid = 1'b0;
  logic [8:0] a_duty;
  logic       a_dv;
  logic       a_busy;
  logic       a_ovr;

  logic       b_rst = 1'b1;
  logic [7:0] b_adc = '0;
  logic [7:0] b_vref = '0;
  logic       b_valid = 1'b0;
  logic [8:0] b_duty;
  logic       b_dv;
  logic       b_busy;
  logic       b_ovr;

  pid_compensator dut_a (
    .clk        (clk),
    .rst        (a_rst),
    .adc_data   (a_adc),
    .adc_valid  (a_valid),
    .vref       (a_vref),
    .duty       (a_duty),
    .duty_valid (a_dv),
    .busy       (a_busy),
    .overrun    (a_ovr)
  );

  pid_compensator #(
    .KA (2047),
    .KB (0),
    .KC (0)
  ) dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .adc_data   (b_adc),
    .adc_valid  (b_valid),
    .vref       (b_vref),
    .duty       (b_duty),
    .duty_valid (b_dv),
    .busy       (b_busy),
    .overrun    (b_ovr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (a_dv) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        ea = qa.pop_front();
        chk("a_duty", int'(a_duty), int'(ea.duty));
        chk("a_latency", cyc, ea.due);
      end
    end
  end

  always @(negedge clk) begin
    if (b_dv) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        eb = qb.pop_front();
        chk("b_duty", int'(b_duty), int'(eb.duty));
        chk("b_latency", cyc, eb.due);
      end
    end
  end

  task automatic reset_a();
    @(posedge clk); #1;
    a_rst = 1'b1;
    a_valid = 1'b0;
    qa.delete();
    repeat (3) @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    chk("a_rst_duty", int'(a_duty), 0);
    chk("a_rst_busy", int'(a_busy), 0);
    chk("a_rst_dv", int'(a_dv), 0);
    chk("a_rst_ovr", int'(a_ovr), 0);
  endtask

  task automatic reset_b();
    @(posedge clk); #1;
    b_rst = 1'b1;
    b_valid = 1'b0;
    qb.delete();
    repeat (3) @(posedge clk);
    #1 b_rst = 1'b0;
    @(negedge clk);
    chk("b_rst_duty", int'(b_duty), 0);
    chk("b_rst_busy", int'(b_busy), 0);
  endtask

  task automatic sample_a(input int vr, input int ad,
                          input int exp, input int gap);
    @(posedge clk); #1;
    a_vref = 8'(vr);
    a_adc = 8'(ad);
    a_valid = 1'b1;
    qa.push_back('{duty: 9'(exp), due: cyc + 5});
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

  task automatic sample_b(input int vr, input int ad,
                          input int exp, input int gap);
    @(posedge clk); #1;
    b_vref = 8'(vr);
    b_adc = 8'(ad);
    b_valid = 1'b1;
    qb.push_back('{duty: 9'(exp), due: cyc + 5});
    @(posedge clk); #1;
    b_valid = 1'b0;
    repeat (gap - 2) @(posedge clk);
  endtask

`ifdef PID_SOFT_START_EN
  localparam int FIRST_STEP = 0;
`else
  localparam int FIRST_STEP = 15;
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    va.push_back('{1, 128, 128, 0, 8});
    for (int i = 0; i < 9; i++) va.push_back('{0, 128, 128, 0, 8});
`ifndef PID_SOFT_START_EN
    va.push_back('{1, 100, 90, 15, 6});
    va.push_back('{0, 100, 90, 5, 6});
    va.push_back('{0, 100, 90, 5, 6});
`endif

    reset_b();
    foreach (va[i]) begin
      if (va[i].rst) reset_a();
      sample_a(va[i].vref, va[i].adc, va[i].exp, va[i].gap);
    end

    // Reset while the update for a sample is still in flight.
    @(posedge clk); #1;
    a_vref = 8'd100;
    a_adc = 8'd90;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk);
    reset_a();
    repeat (8) @(posedge clk);
    sample_a(100, 90, FIRST_STEP, 8);
    chk("a_hold", int'(a_duty), FIRST_STEP);

`ifndef PID_SOFT_START_EN
    // Strobes in MB and on the SAT->IDLE edge are dropped.
    reset_a();
    @(posedge clk); #1;
    a_vref = 8'd100;
    a_adc = 8'd90;
    a_valid = 1'b1;
    qa.push_back('{duty: 9'd15, due: cyc + 5});
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    a_vref = 8'd0;
    a_adc = 8'd100;
    a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("a_ovr_mb", int'(a_ovr), 1);
    chk("a_busy_mb", int'(a_busy), 1);
    @(posedge clk); #1;
    a_valid = 1'b1;
    @(negedge clk);
    chk("a_ovr_pulse_end", int'(a_ovr), 0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    chk("a_ovr_sat_edge", int'(a_ovr), 1);
    chk("a_idle_after_sat", int'(a_busy), 0);
    repeat (3) @(posedge clk);
    sample_a(100, 90, 5, 6);
    sample_a(100, 90, 5, 6);

    // Saturation high, then recovery shows no windup; then low clamp.
    sample_b(255, 0, 511, 6);
    sample_b(0, 2, 495, 6);
    reset_b();
    sample_b(0, 50, 0, 6);
    sample_b(0, 50, 0, 6);
`else
    for (int k = 0; k < 132; k++) begin
      sample_b(255, 0, (4 * k > 511) ? 511 : 4 * k, 6);
    end
`endif

    for (int i = 0; i < 20 && (qa.size() + qb.size()) != 0; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain", qa.size() + qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pid_compensator.md
Name: pid_compensator

Overview:
- Digital 3-tap PID compensator for the buck loop. Sits directly upstream of the dither DPWM and drives its 9-bit duty command input.
- Takes one ADC output-voltage sample per strobe and forms error = vref - adc.
- Computes the incremental law u[n] = u[n-1] + KA*e[n] + KB*e[n-1] + KC*e[n-2] using one shared multiplier, time-multiplexed by an FSM.
- Emits a saturated duty word and a one-cycle valid pulse.

Parameters:
- ADC_W, 8, ADC sample and vref width (unsigned)
- DUTY_W, 9, duty command width (unsigned)
- COEF_W, 12, signed coefficient width
- COEF_FRAC, 8, fractional bits of coefficients and internal u
- KA, 384, signed e[n] coefficient (1.5)
- KB, -640, signed e[n-1] coefficient (-2.5)
- KC, 272, signed e[n-2] coefficient (1.0625)
- DUTY_MAX, 511, upper duty clamp (integer)
- SS_STEP, 4, soft-start limit increment per update (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- adc_data  in  ADC_W  unsigned output-voltage sample
- adc_valid  in  1  sample strobe, one cycle
- vref  in  ADC_W  unsigned setpoint, sampled with adc_data
- duty  out  DUTY_W  duty command to the dither DPWM
- duty_valid  out  1  one-cycle pulse when duty updates
- busy  out  1  high while the FSM is not IDLE
- overrun  out  1  one-cycle pulse when a sample is dropped

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state changes happen on the rising edge of clk.
- Reset values: duty=0, duty_valid=0, busy=0, overrun=0, state=IDLE, e1=e2=0, acc=0, u=0.
- Error: e0 = {0,vref} - {0,adc_data}, an ADC_W+1-bit signed value, captured on the edge where state=IDLE and adc_valid=1.
- FSM states: IDLE -> MA -> MB -> MC -> SAT -> IDLE. Each non-IDLE state lasts exactly one cycle.
  - IDLE: on adc_valid, capture e0 and load acc=u; go to MA.
  - MA: acc += KA*e0.
  - MB: acc += KB*e1.
  - MC: acc += KC*e2.
  - SAT: clamp acc to [0, UB<<COEF_FRAC], where UB = DUTY_MAX. Write the clamped value to u (anti-windup). Write duty = u_clamped >> COEF_FRAC (truncate). Shift history: e2<=e1, e1<=e0. Set duty_valid=1 for the following cycle.
- Latency: duty/duty_valid appear 5 edges after the capture edge. Minimum sample spacing is 5 cycles.
- Widths:
  - Products are ADC_W+1+COEF_W bits, signed.
  - acc is DUTY_W+COEF_FRAC+ADC_W+4 bits, signed, so the sum of three products plus u cannot overflow.
  - Saturation is applied only in SAT.
- duty holds its value between updates. duty_valid is 0 except the single cycle after SAT.
- Overrun: adc_valid asserted while state is not IDLE is ignored. overrun pulses on the next cycle. History is unaffected.
- adc_valid in the same cycle the FSM returns to IDLE (SAT -> IDLE edge) counts as busy and is dropped.
- Reset mid-operation: the FSM goes to IDLE and all registers return to reset values. A pending update is discarded and no duty_valid is issued.

Optional Feature:
- Macro: PID_SOFT_START_EN.
- Defined:
  - Register lim (DUTY_W bits) resets to 0.
  - Each SAT update sets lim = min(lim+SS_STEP, DUTY_MAX), applied after that update's clamp.
  - The clamp upper bound UB = lim, read before the increment, is used for both duty and u.
- Undefined: no lim register; UB = DUTY_MAX always.

Decomposition:
- Package dpwm_pkg contains:
  - ADC_W and DUTY_W defaults.
  - FSM state encoding localparams (IDLE, MA, MB, MC, SAT).
  - A signed saturate-to-range function.
- Sub-module pid_mac: a registered signed multiply-accumulate (acc_in + coef*err) with coefficient/operand mux select from the FSM.

Test Plan:
- Reset: assert rst for 3 cycles at any state -> duty=0, busy=0, duty_valid=0; a subsequent sample behaves as the first after power-up.
- Zero error: vref=128, adc=128, 10 samples spaced 8 cycles -> duty=0 after each duty_valid, which occurs exactly 5 edges after each strobe.
- Step response with default coefficients: vref=100, adc=90 repeatedly (e=10):
  - u=3840, duty=15
  - then u=1280, duty=5
  - then u=1440, duty=5
- High saturation/anti-windup: bench KA=2047, KB=KC=0; vref=255, adc=0 -> duty=511 and u=130816. Next sample with vref=0, adc=2 (e=-2) -> u=126722, duty=495, proving the integrator did not wind up.
- Low clamp and overrun: u=0 state, e=-50 -> duty=0. A strobe during MB -> overrun pulse for one cycle, no extra duty_valid, history unchanged.
- PID_SOFT_START_EN defined, KA=2047, e=255 repeatedly -> duty sequence 0,4,8,12,... to 511, then holds at 511.
